// File: rtl/ff_readback_pkg.sv
// Shared definitions for the flip-flop state readback block.
// Contents:
//   state_t    - readback FSM states (IDLE, SEND)
//   num_words  - number of WORD_W-bit words needed to cover NUM_FF bits
//   idx_width  - word index width, never less than one bit
package ff_readback_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int num_words(input int num_ff, input int word_w);
    return (num_ff + word_w - 1) / word_w;
  endfunction

  // A single-word stream still needs a 1-bit index register.
  function automatic int idx_width(input int n_words);
    return (n_words <= 1) ? 1 : $clog2(n_words);
  endfunction

endpackage

// File: rtl/rb_word_mux.sv
// Word selector for the readback stream.
// Picks word idx out of the zero-padded shadow vector. Purely combinational;
// the parent registers the result.
// Ports:
//   vec  in  NUM_WORDS*WORD_W  padded shadow vector, word 0 in the LSBs
//   idx  in  IDX_W             word index
//   word out WORD_W            selected word (zero for out-of-range idx)
module rb_word_mux
  import ff_readback_pkg::*;
#(
  parameter int NUM_WORDS = 2,
  parameter int WORD_W    = 8,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_WORDS*WORD_W-1:0] vec,
  input  logic [IDX_W-1:0]            idx,
  output logic [WORD_W-1:0]           word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        word = vec[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/ff_state_readback.sv
// Flip-flop state readback.
// Takes a parallel snapshot of the fabric FF Q outputs on request and streams
// it out word by word (word 0 = bits [WORD_W-1:0]) over valid/ready.
// Ports:
//   clk       in   fabric clock, rising edge
//   reset     in   synchronous, active-low reset
//   ff_q_bus  in   NUM_FF Q outputs, bit i = FF i
//   snap_req  in   one-cycle capture-and-stream request
//   rb_abort  in   abandon the current readback
//   rb_data   out  current readback word (registered)
//   rb_valid  out  rb_data valid (registered)
//   rb_ready  in   consumer accepts the word
//   rb_last   out  current word is the final one (registered)
//   busy      out  snapshot held / stream in progress
//   snap_ovf  out  sticky: snap_req seen while busy
module ff_state_readback
  import ff_readback_pkg::*;
#(
  parameter int NUM_FF = 16,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_FF-1:0] ff_q_bus,
  input  logic              snap_req,
  input  logic              rb_abort,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              rb_last,
  output logic              busy,
  output logic              snap_ovf
);

  localparam int NUM_WORDS = num_words(NUM_FF, WORD_W);
  localparam int IDX_W     = idx_width(NUM_WORDS);
  localparam int PAD_W     = NUM_WORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t             state, state_nxt;
  logic [PAD_W-1:0]   shadow, shadow_nxt;
  logic [PAD_W-1:0]   ff_pad;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               ovf_nxt;
  logic [WORD_W-1:0]  word_nxt;
  logic [WORD_W-1:0]  data_nxt;
  logic               valid_nxt;
  logic               last_nxt;

  // Bits above NUM_FF in the last word read back as zero.
  always_comb begin
    ff_pad             = '0;
    ff_pad[NUM_FF-1:0] = ff_q_bus;
  end

  // State register plus the registered stream outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      shadow   <= '0;
      idx      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      rb_last  <= 1'b0;
      snap_ovf <= 1'b0;
    end else begin
      state    <= state_nxt;
      shadow   <= shadow_nxt;
      idx      <= idx_nxt;
      rb_data  <= data_nxt;
      rb_valid <= valid_nxt;
      rb_last  <= last_nxt;
      snap_ovf <= ovf_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    idx_nxt    = idx;
    ovf_nxt    = snap_ovf;
    unique case (state)
      IDLE: begin
        // Abort beats a same-cycle request: nothing is captured.
        if (snap_req && !rb_abort) begin
          shadow_nxt = ff_pad;
          idx_nxt    = '0;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        // Still SEND on the final handshake, so a request there is an overrun.
        if (snap_req) begin
          ovf_nxt = 1'b1;
        end
        if (rb_valid && rb_ready) begin
          if (rb_last) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
        // The shadow is left stale on abort; rb_data is zeroed below.
        if (rb_abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // The output registers load from the next shadow/index so the word for the
  // next cycle is ready right at the edge, with no rb_ready -> rb_valid path.
  rb_word_mux #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W),
    .IDX_W     (IDX_W)
  ) u_word_mux (
    .vec  (shadow_nxt),
    .idx  (idx_nxt),
    .word (word_nxt)
  );

  // Output logic.
  always_comb begin
    valid_nxt = (state_nxt == SEND);
    last_nxt  = valid_nxt && (idx_nxt == LAST_IDX);
    data_nxt  = valid_nxt ? word_nxt : '0;
  end

  assign busy = (state == SEND);

endmodule
